// File: rtl/key_pkg.sv
// Shared constants, state type and small helpers for the keypad debouncer.
package key_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_e;

    // Number of set bits in an 11-bit key vector (0..11).
    function automatic logic [3:0] key_count(input logic [10:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 11; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Key code of a one-hot {star, digits} vector; KEY_NONE when empty.
    function automatic logic [3:0] key_encode(input logic [10:0] v);
        logic [3:0] code;
        code = KEY_NONE;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                code = 4'(i);
            end
        end
        if (v[10]) begin
            code = KEY_STAR;
        end
        return code;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module sync2 #(
    parameter int unsigned Width = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce_edge.sv
// Keypad debouncer: one shared settle counter for all 11 keys, followed by
// press-edge detection producing one-cycle pulses and a key code.
module key_debounce_edge
    import key_pkg::*;
#(
    parameter logic [19:0] T_20MS = 20'hF_4240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] bt_i,
    input  logic       btstar_i,
    output logic [9:0] bt_o,
    output logic       btstar_o,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       multi_err
);

    localparam logic [19:0] T_LAST = T_20MS - 20'd1;

    logic [10:0] s;

    state_e      state_q, state_d;
    logic [10:0] cand_q, cand_d;
    logic [10:0] stab_q, stab_d;
    logic [19:0] cnt_q, cnt_d;
    logic [10:0] rise_q, rise_d;

    logic [9:0]  bt_q, bt_d;
    logic        btstar_q, btstar_d;
    logic        valid_q, valid_d;
    logic [3:0]  code_q, code_d;
    logic        multi_q, multi_d;

    sync2 #(
        .Width(11)
    ) u_sync2 (
        .clk(clk),
        .rst(rst),
        .d_i({btstar_i, bt_i}),
        .q_o(s)
    );

    // Debounce FSM: any change restarts settling; the update cycle latches
    // the candidate into the stable register and captures the rising keys.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        if (s != cand_q) begin
            cand_d  = s;
            cnt_d   = '0;
            state_d = SETTLING;
        end else if (state_q == SETTLING) begin
            if (cnt_q == T_LAST) begin
                stab_d  = cand_q;
                cnt_d   = '0;
                state_d = STABLE;
                rise_d  = cand_q & ~stab_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // Pulse decode from the captured rise vector; idle code is KEY_NONE.
    always_comb begin
        bt_d     = '0;
        btstar_d = 1'b0;
        valid_d  = 1'b0;
        code_d   = KEY_NONE;
        multi_d  = 1'b0;
        if (key_count(rise_q) == 4'd1) begin
            bt_d     = rise_q[9:0];
            btstar_d = rise_q[10];
            valid_d  = 1'b1;
            code_d   = key_encode(rise_q);
        end else if (key_count(rise_q) > 4'd1) begin
            multi_d = 1'b1;
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STABLE;
            cand_q   <= '0;
            stab_q   <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            bt_q     <= '0;
            btstar_q <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= KEY_NONE;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stab_q   <= stab_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            bt_q     <= bt_d;
            btstar_q <= btstar_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            multi_q  <= multi_d;
        end
    end

    assign bt_o      = bt_q;
    assign btstar_o  = btstar_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign multi_err = multi_q;

endmodule

// File: tb/tb_key_debounce_edge.sv
// Directed bench for key_debounce_edge with T_20MS=4 (pulse 7 cycles after the
// first edge that samples a new raw level). Outputs are sampled on negedges.
module tb_key_debounce_edge;

    logic       clk;
    logic       rst;
    logic [9:0] bt_i;
    logic       btstar_i;
    logic [9:0] bt_o;
    logic       btstar_o;
    logic       key_valid;
    logic [3:0] key_code;
    logic       multi_err;

    int vectors;
    int errors;

    // {bt_o, btstar_o, key_valid, key_code, multi_err}
    localparam logic [16:0] IDLE = {10'b0, 1'b0, 1'b0, 4'd15, 1'b0};

    key_debounce_edge #(
        .T_20MS(20'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bt_i(bt_i),
        .btstar_i(btstar_i),
        .bt_o(bt_o),
        .btstar_o(btstar_o),
        .key_valid(key_valid),
        .key_code(key_code),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
            $display("FAIL reset_async got=%h want=%h",
                     {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
            errors++;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL reset_idle k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
    endtask

    task automatic test_single_press;
        logic [16:0] exp;
        bt_i[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b00_0000_1000, 1'b0, 1'b1, 4'd3, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL single_press k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL single_release k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
    endtask

    task automatic test_bounce;
        logic [7:0]  pat;
        logic [16:0] exp;
        pat = 8'b0011_0011; // bit j drives edge j: 1,1,0,0,1,1,0,0
        for (int j = 0; j < 8; j++) begin
            bt_i[5] = pat[j];
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL bounce_quiet j=%0d got=%h want=%h", j,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
        bt_i[5] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b00_0010_0000, 1'b0, 1'b1, 4'd5, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL bounce_press k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[5] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_multi;
        logic [16:0] exp;
        bt_i[1]  = 1'b1;
        btstar_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b0, 1'b0, 1'b0, 4'd15, 1'b1} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL multi k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[1]  = 1'b0;
        btstar_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL multi_release k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
    endtask

    task automatic test_held_then_star;
        logic [16:0] exp;
        bt_i[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b00_0000_0100, 1'b0, 1'b1, 4'd2, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL held_digit k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        btstar_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b0, 1'b1, 1'b1, 4'd10, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL held_star k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[2]  = 1'b0;
        btstar_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL held_release k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
    endtask

    task automatic test_glitch;
        bt_i[7] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) bt_i[7] = 1'b0;
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL glitch k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_settling;
        logic [16:0] exp;
        bt_i[4] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
            $display("FAIL rst_settle_now got=%h want=%h",
                     {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
            errors++;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
                $display("FAIL rst_settle_hold k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
                errors++;
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b00_0001_0000, 1'b0, 1'b1, 4'd4, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL rst_settle_held k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[4] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_reset_during_pulse;
        logic [16:0] exp;
        bt_i[6] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        exp = {10'b00_0100_0000, 1'b0, 1'b1, 4'd6, 1'b0};
        vectors++;
        if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
            $display("FAIL pulse_before_rst got=%h want=%h",
                     {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
            errors++;
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== IDLE) begin
            $display("FAIL rst_clears_pulse got=%h want=%h",
                     {bt_o, btstar_o, key_valid, key_code, multi_err}, IDLE);
            errors++;
        end
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k == 7) ? {10'b00_0100_0000, 1'b0, 1'b1, 4'd6, 1'b0} : IDLE;
            vectors++;
            if ({bt_o, btstar_o, key_valid, key_code, multi_err} !== exp) begin
                $display("FAIL rst_pulse_held k=%0d got=%h want=%h", k,
                         {bt_o, btstar_o, key_valid, key_code, multi_err}, exp);
                errors++;
            end
        end
        bt_i[6] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        bt_i     = '0;
        btstar_i = 1'b0;
        vectors  = 0;
        errors   = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_held_then_star();
        test_glitch();
        test_reset_mid_settling();
        test_reset_during_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_debounce_edge.md
KEY_DEBOUNCE_EDGE -- requirements
Module: key_debounce_edge

Interface
REQ-001 Parameter T_20MS, default 20'hF_4240 (1,000,000 cycles at 50 MHz), debounce settle time in clk cycles; legal range 2..2^20-1.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 bt_i  input  10  raw digit keys 0-9; 1 = pressed; asynchronous to clk.
REQ-005 btstar_i  input  1  raw star key; 1 = pressed; asynchronous.
REQ-006 bt_o  output  10  one-cycle press pulses, one bit per digit key; feeds the doorlock FSM.
REQ-007 btstar_o  output  1  one-cycle star press pulse.
REQ-008 key_valid  output  1  one-cycle strobe, high exactly when one bit of {btstar_o, bt_o} is high.
REQ-009 key_code  output  4  code of the pulsed key: 0-9 digit, 10 star, 15 none; valid when key_valid=1.
REQ-010 multi_err  output  1  one-cycle pulse: more than one key rose in the same debounced update.

Function
REQ-011 The 11 raw inputs, as vector {btstar_i, bt_i}, SHALL pass through a two-flop synchronizer before any other use.
REQ-012 The block SHALL debounce the whole vector with one shared counter (cnt, 20 bits), a candidate register cand, and a stable register stab.
REQ-013 FSM states: STABLE, SETTLING; reset state STABLE.
REQ-014 Any cycle with synchronized vector s != cand: cand<=s, cnt<=0, state<=SETTLING, from either state.
REQ-015 SETTLING with s == cand and cnt < T_20MS-1: cnt increments by 1.
REQ-016 SETTLING with s == cand and cnt == T_20MS-1: stab<=cand, state<=STABLE, cnt<=0 (the update cycle).
REQ-017 STABLE with s == cand: no register changes; cnt holds 0.
REQ-018 Rise vector r = cand & ~stab, evaluated only in the update cycle; zero otherwise.
REQ-019 Exactly one bit of r set: the matching pulse output, key_valid and key_code SHALL be registered high/valid for exactly one cycle after the update edge.
REQ-020 Two or more bits of r set: no key pulse; key_valid=0; key_code=15; multi_err pulses one cycle.
REQ-021 Releases (1->0 in stab) SHALL produce no pulse.
REQ-022 A new key pressed while another is held SHALL count as a single rise and pulse normally.
REQ-023 Glitches shorter than T_20MS cycles at the synchronizer output SHALL produce no output change.
REQ-024 Latency: from the first clk edge sampling a stable new raw level to the output pulse = T_20MS+3 cycles, fixed.
REQ-025 cnt SHALL never exceed T_20MS-1 or wrap.
REQ-026 Outside pulse cycles all outputs = 0, except key_code = 15.

Reset
REQ-027 rst=1 SHALL immediately clear synchronizer flops, cand, stab, cnt, bt_o, btstar_o, key_valid and multi_err to 0, set key_code=15 and state=STABLE, regardless of the clock.
REQ-028 A key held through reset release: cand and stab both clear, so the held key SHALL pulse once after T_20MS+3 cycles.
REQ-029 Reset asserted mid-SETTLING SHALL discard the pending update; no pulse SHALL escape.

Structure
REQ-030 Shared package key_pkg SHALL hold the KEY_STAR=4'd10 and KEY_NONE=4'd15 constants and the state typedef {STABLE, SETTLING}.
REQ-031 The two-flop synchronizer SHALL be a separate sub-module sync2, parameterized by width and instantiated once with width 11.
REQ-032 Target size 120-400 RTL lines; no latches; every output registered.

Verification (T_20MS=4)
REQ-033 bt_i[3] rises and holds -> bt_o[3], key_valid=1, key_code=3 for exactly 1 cycle, 7 cycles after the first sampling edge.
REQ-034 bt_i[5] bounces 1,0,1,0 at 2-cycle intervals, then holds 1 -> exactly one bt_o[5] pulse, 7 cycles after the final rise.
REQ-035 bt_i[1] and btstar_i rise together -> multi_err pulses once; bt_o=0, btstar_o=0, key_code=15.
REQ-036 bt_i[2] held, then btstar_i rises -> one btstar_o pulse with key_code=10; release of both produces no pulse.
REQ-037 3-cycle bt_i[7] glitch -> no output; rst asserted mid-SETTLING -> all outputs 0 and key_code=15 at once; held key pulses 7 cycles after rst release.
